// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Holds the loader state encoding, the default frame start marker and the
// frame field widths.
package imem_boot_loader_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned LEN_W             = 16;
  localparam int unsigned WORD_W            = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } boot_state_e;

  // Input is open in every state except the two terminal ones.
  function automatic logic rx_open(input boot_state_e s);
    return (s != ST_DONE) && (s != ST_ERROR);
  endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Byte-to-word packer for the boot loader.
// Collects four little-endian bytes into a 32-bit word and issues a single
// registered write strobe with the address supplied by the loader.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   clear           drop any partial word and return to lane 0
//   byte_valid      byte_data is a payload byte accepted this cycle
//   byte_data       payload byte
//   word_addr       address to attach to the word being completed
//   word_done       combinational: this byte completes a word
//   imem_we/addr/wdata  registered write port toward instruction memory
module boot_word_packer
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  input  logic [ADDR_W-1:0] word_addr,
  output logic              word_done,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata
);

  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       part_q, part_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;

  always_comb begin
    byte_idx_d = byte_idx_q;
    part_d     = part_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    word_done  = byte_valid && (byte_idx_q == 2'd3);
    if (clear) begin
      byte_idx_d = '0;
      part_d     = '0;
    end else if (byte_valid) begin
      byte_idx_d = byte_idx_q + 2'd1;
      case (byte_idx_q)
        2'd0:    part_d[7:0]   = byte_data;
        2'd1:    part_d[15:8]  = byte_data;
        2'd2:    part_d[23:16] = byte_data;
        default: ;
      endcase
      // Lane 3 goes straight into the output word so the strobe lands
      // one cycle after the fourth byte without an extra stage.
      if (word_done) begin
        we_d    = 1'b1;
        addr_d  = word_addr;
        wdata_d = {byte_data, part_q};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_idx_q <= '0;
      part_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      part_q     <= part_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader.
// Receives a framed byte stream (SYNC, LEN_LO, LEN_HI, 4*N payload bytes,
// XOR checksum), writes little-endian words into instruction memory and
// holds the core in reset until a verified image has been loaded.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   rx_valid/rx_data      incoming byte stream; rx_ready registered back-pressure
//   rearm                 pulse: leave DONE/ERROR and return to IDLE
//   imem_we/addr/wdata    instruction memory load port
//   core_hold             1 keeps the core in reset
//   boot_done/boot_error  status levels
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              rearm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              boot_done,
  output logic              boot_error
);

  localparam logic [LEN_W:0] MAX_WORDS = (LEN_W+1)'(1) << ADDR_W;

  boot_state_e       state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [7:0]        chk_acc_q, chk_acc_d;
  logic              rx_ready_q, rx_ready_d;
  logic              core_hold_q, core_hold_d;
  logic              boot_done_q, boot_done_d;
  logic              boot_error_q, boot_error_d;

  logic              accept;
  logic              data_valid;
  logic              pack_clear;
  logic              word_done;
  logic [LEN_W-1:0]  len_rx;
  logic [LEN_W-1:0]  cnt_next;

  assign accept = rx_valid & rx_ready_q;

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    chk_acc_d  = chk_acc_q;
    data_valid = 1'b0;
    pack_clear = 1'b0;
    len_rx     = {rx_data, len_lo_q};
    cnt_next   = LEN_W'(word_cnt_q) + 16'd1;

    case (state_q)
      ST_IDLE: begin
        if (accept && (rx_data == SYNC_BYTE)) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_lo_d = rx_data;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d = len_rx;
          if (len_rx == '0)                   state_d = ST_CHECK;
          else if ({1'b0, len_rx} > MAX_WORDS) state_d = ST_ERROR;
          else                                 state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          data_valid = 1'b1;
          chk_acc_d  = chk_acc_q ^ rx_data;
          if (word_done) begin
            word_cnt_d = word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
            if (cnt_next == len_q) state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (accept) state_d = (rx_data == chk_acc_q) ? ST_DONE : ST_ERROR;
      end
      ST_DONE, ST_ERROR: begin
        if (rearm) begin
          state_d    = ST_IDLE;
          len_lo_d   = '0;
          len_d      = '0;
          word_cnt_d = '0;
          chk_acc_d  = '0;
          pack_clear = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered from the next state so they change on
    // the same edge that moves the FSM.
    rx_ready_d   = rx_open(state_d);
    core_hold_d  = (state_d != ST_DONE);
    boot_done_d  = (state_d == ST_DONE);
    boot_error_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      len_lo_q     <= '0;
      len_q        <= '0;
      word_cnt_q   <= '0;
      chk_acc_q    <= '0;
      rx_ready_q   <= 1'b0;
      core_hold_q  <= 1'b1;
      boot_done_q  <= 1'b0;
      boot_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      chk_acc_q    <= chk_acc_d;
      rx_ready_q   <= rx_ready_d;
      core_hold_q  <= core_hold_d;
      boot_done_q  <= boot_done_d;
      boot_error_q <= boot_error_d;
    end
  end

  boot_word_packer #(
    .ADDR_W (ADDR_W)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pack_clear),
    .byte_valid (data_valid),
    .byte_data  (rx_data),
    .word_addr  (word_cnt_q[ADDR_W-1:0]),
    .word_done  (word_done),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata)
  );

  assign rx_ready   = rx_ready_q;
  assign core_hold  = core_hold_q;
  assign boot_done  = boot_done_q;
  assign boot_error = boot_error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic              rearm = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              boot_done;
  logic              boot_error;

  imem_boot_loader #(
    .ADDR_W    (ADDR_W),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .rearm      (rearm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .boot_done  (boot_done),
    .boot_error (boot_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observed writes {addr, data}, captured away from the active edge.
  logic [39:0] wr_q[$];
  always @(negedge clk) if (imem_we) wr_q.push_back({imem_addr, imem_wdata});

  // Reference model state: frame bytes to send and writes it must produce.
  logic [31:0] words[$];
  logic [7:0]  fb[$];
  logic [39:0] exp_q[$];

  // Frame from the specification's rules: header, LE payload, XOR checksum.
  task automatic build_frame(input logic [7:0] chk_delta);
    logic [7:0]  chk;
    logic [15:0] n;
    logic [31:0] w;
    fb.delete();
    exp_q.delete();
    n   = 16'(words.size());
    chk = 8'h00;
    fb.push_back(8'hA5);
    fb.push_back(n[7:0]);
    fb.push_back(n[15:8]);
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      for (int b = 0; b < 4; b++) begin
        fb.push_back(w[8*b +: 8]);
        chk = chk ^ w[8*b +: 8];
      end
      exp_q.push_back({8'(i), w});
    end
    fb.push_back(chk ^ chk_delta);
  endtask

  // Sends the first 'count' bytes of fb with random idle gaps of up to max_gap.
  // Always entered and left on a falling edge.
  task automatic drive_bytes(input int unsigned max_gap, input int unsigned count);
    int unsigned n;
    int unsigned gap;
    for (int unsigned i = 0; i < count && i < fb.size(); i++) begin
      gap = $urandom_range(max_gap, 0);
      repeat (gap) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_data  = fb[i];
      n = 0;
      while (!rx_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!rx_ready) begin
        total++;
        bad++;
        $display("FAIL rx_ready_timeout byte=%0d got=0 exp=1", i);
        rx_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic pulse_rearm();
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({rx_ready, imem_we, imem_addr, imem_wdata, core_hold, boot_done, boot_error} !==
        {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values got=%b%b %h %h %b%b%b exp=00 00 00000000 100",
               rx_ready, imem_we, imem_addr, imem_wdata, core_hold, boot_done, boot_error);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (rx_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset got=%b exp=1", rx_ready);
    end
  endtask

  task automatic test_basic();
    wr_q.delete();
    words.delete();
    words.push_back(32'h0000_0013);
    words.push_back(32'h0010_0093);
    build_frame(8'h00);
    drive_bytes(0, fb.size());
    total++;
    if (wr_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL basic_wr_count got=%0d exp=%0d", wr_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        total++;
        if (wr_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL basic_wr got=%h exp=%h", wr_q[i], exp_q[i]);
        end
      end
    end
    total++;
    if ({boot_done, boot_error, core_hold, rx_ready} !== 4'b1000) begin
      bad++;
      $display("FAIL basic_status got=%b exp=1000", {boot_done, boot_error, core_hold, rx_ready});
    end
    pulse_rearm();
  endtask

  task automatic test_bad_chk();
    wr_q.delete();
    words.delete();
    words.push_back(32'h0000_0013);
    words.push_back(32'h0010_0093);
    build_frame(8'h14);
    drive_bytes(0, fb.size());
    total++;
    if (wr_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL badchk_wr_count got=%0d exp=%0d", wr_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        total++;
        if (wr_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL badchk_wr got=%h exp=%h", wr_q[i], exp_q[i]);
        end
      end
    end
    total++;
    if ({boot_done, boot_error, core_hold, rx_ready} !== 4'b0110) begin
      bad++;
      $display("FAIL badchk_status got=%b exp=0110", {boot_done, boot_error, core_hold, rx_ready});
    end
    pulse_rearm();
    total++;
    if ({boot_done, boot_error, core_hold, rx_ready} !== 4'b0011) begin
      bad++;
      $display("FAIL rearm_status got=%b exp=0011", {boot_done, boot_error, core_hold, rx_ready});
    end
  endtask

  task automatic test_junk_zero_len();
    wr_q.delete();
    words.delete();
    build_frame(8'h00);
    fb.push_front(8'h5A);
    fb.push_front(8'hFF);
    fb.push_front(8'h00);
    drive_bytes(1, fb.size());
    total++;
    if (wr_q.size() != 0) begin
      bad++;
      $display("FAIL zero_len_writes got=%0d exp=0", wr_q.size());
    end
    total++;
    if ({boot_done, boot_error, core_hold} !== 3'b100) begin
      bad++;
      $display("FAIL zero_len_status got=%b exp=100", {boot_done, boot_error, core_hold});
    end
    pulse_rearm();
  endtask

  task automatic test_length_bounds();
    wr_q.delete();
    fb.delete();
    fb.push_back(8'hA5);
    fb.push_back(8'h01);
    fb.push_back(8'h01);
    drive_bytes(0, fb.size());
    total++;
    if ({boot_error, boot_done, core_hold, rx_ready} !== 4'b1010) begin
      bad++;
      $display("FAIL overflow_status got=%b exp=1010", {boot_error, boot_done, core_hold, rx_ready});
    end
    repeat (2) @(negedge clk);
    total++;
    if (wr_q.size() != 0) begin
      bad++;
      $display("FAIL overflow_writes got=%0d exp=0", wr_q.size());
    end
    pulse_rearm();

    wr_q.delete();
    words.delete();
    for (int i = 0; i < 256; i++) words.push_back($urandom);
    build_frame(8'h00);
    drive_bytes(0, fb.size());
    total++;
    if (wr_q.size() != 256) begin
      bad++;
      $display("FAIL full_wr_count got=%0d exp=256", wr_q.size());
    end else begin
      for (int i = 0; i < 256; i++) begin
        total++;
        if (wr_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL full_wr idx=%0d got=%h exp=%h", i, wr_q[i], exp_q[i]);
        end
      end
      total++;
      if (wr_q[255][39:32] !== 8'hFF) begin
        bad++;
        $display("FAIL full_last_addr got=%h exp=ff", wr_q[255][39:32]);
      end
    end
    total++;
    if ({boot_done, boot_error, core_hold} !== 3'b100) begin
      bad++;
      $display("FAIL full_status got=%b exp=100", {boot_done, boot_error, core_hold});
    end
    pulse_rearm();
  endtask

  task automatic test_stall();
    logic [39:0] ref_q[$];
    words.delete();
    for (int i = 0; i < 7; i++) words.push_back($urandom);
    build_frame(8'h00);
    for (int pass = 0; pass < 2; pass++) begin
      wr_q.delete();
      drive_bytes((pass == 0) ? 0 : 4, fb.size());
      if (pass == 0) ref_q = wr_q;
      total++;
      if (wr_q.size() != exp_q.size()) begin
        bad++;
        $display("FAIL stall_wr_count pass=%0d got=%0d exp=%0d", pass, wr_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          total++;
          if (wr_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL stall_wr pass=%0d got=%h exp=%h", pass, wr_q[i], exp_q[i]);
          end
        end
      end
      total++;
      if (boot_done !== 1'b1) begin
        bad++;
        $display("FAIL stall_done pass=%0d got=%b exp=1", pass, boot_done);
      end
      pulse_rearm();
    end
    total++;
    if (ref_q.size() != wr_q.size()) begin
      bad++;
      $display("FAIL stall_vs_b2b got=%0d exp=%0d", wr_q.size(), ref_q.size());
    end
  endtask

  task automatic test_mid_reset();
    wr_q.delete();
    words.delete();
    for (int i = 0; i < 4; i++) words.push_back($urandom);
    build_frame(8'h00);
    drive_bytes(0, 5);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({imem_we, core_hold, rx_ready, boot_done, boot_error, imem_wdata} !==
        {5'b01000, 32'h0}) begin
      bad++;
      $display("FAIL mid_reset got=%b%b%b%b%b %h exp=01000 00000000",
               imem_we, core_hold, rx_ready, boot_done, boot_error, imem_wdata);
    end
    reset = 1'b1;
    @(negedge clk);
    wr_q.delete();
    words.delete();
    for (int i = 0; i < 3; i++) words.push_back($urandom);
    build_frame(8'h00);
    drive_bytes(2, fb.size());
    total++;
    if (wr_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL after_reset_wr_count got=%0d exp=%0d", wr_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        total++;
        if (wr_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL after_reset_wr got=%h exp=%h", wr_q[i], exp_q[i]);
        end
      end
    end
    total++;
    if (boot_done !== 1'b1) begin
      bad++;
      $display("FAIL after_reset_done got=%b exp=1", boot_done);
    end
    pulse_rearm();
  endtask

  task automatic test_back_to_back();
    logic [7:0] delta;
    for (int f = 0; f < 4; f++) begin
      wr_q.delete();
      words.delete();
      for (int i = 0; i < int'($urandom_range(6, 1)); i++) words.push_back($urandom);
      delta = (f == 2) ? 8'($urandom_range(255, 1)) : 8'h00;
      build_frame(delta);
      drive_bytes((f % 2 == 0) ? 0 : 3, fb.size());
      total++;
      if (wr_q.size() != exp_q.size()) begin
        bad++;
        $display("FAIL b2b_wr_count frame=%0d got=%0d exp=%0d", f, wr_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          total++;
          if (wr_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL b2b_wr frame=%0d got=%h exp=%h", f, wr_q[i], exp_q[i]);
          end
        end
      end
      total++;
      if ({boot_done, boot_error} !== ((delta == 8'h00) ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL b2b_status frame=%0d got=%b exp=%b", f, {boot_done, boot_error},
                 (delta == 8'h00) ? 2'b10 : 2'b01);
      end
      pulse_rearm();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_bad_chk();
    test_junk_zero_len();
    test_length_bounds();
    test_stall();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
